// File: rtl/prio_mem_arbiter.sv
// Priority / round-robin memory arbiter with an in-order routing FIFO for responses.
// Optional per-channel grant and drop counters are enabled by MEM_ARB_STATS_EN.
module prio_mem_arbiter #(
    parameter int CNT         = 2,
    parameter int QUEUE_DEPTH = 2,
    parameter int MODE        = 0,
    parameter int REQ_W       = 64,
    parameter int RESP_W      = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CNT-1:0]               master_req_valid,
    output logic [CNT-1:0]               master_req_ready,
    input  logic [CNT-1:0][REQ_W-1:0]    master_req_data,
    output logic [CNT-1:0]               master_resp_valid,
    input  logic [CNT-1:0]               master_resp_ready,
    output logic [CNT-1:0][RESP_W-1:0]   master_resp_data,
    output logic                         slave_req_valid,
    input  logic                         slave_req_ready,
    output logic [REQ_W-1:0]             slave_req_data,
    input  logic                         slave_resp_valid,
    output logic                         slave_resp_ready,
    input  logic [RESP_W-1:0]            slave_resp_data,
    input  logic [CNT-1:0]               flush
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [CNT-1:0][31:0]         grant_cnt,
    output logic [31:0]                  drop_cnt
`endif
);

    localparam int IW = (CNT > 1) ? $clog2(CNT) : 1;
    localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    logic [IW-1:0]          idx_q [QUEUE_DEPTH];
    logic [IW-1:0]          idx_d [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] disc_q, disc_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          occ_q, occ_d;
    logic [IW-1:0]          rr_ptr_q, rr_ptr_d;

    logic [IW-1:0] sel;
    logic          any_req;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [IW-1:0] head_idx;
    logic          head_drop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(QUEUE_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Scan from the highest candidate down so the first match in priority order wins.
    always_comb begin : sel_p
        int c;
        c   = 0;
        sel = '0;
        for (int k = CNT - 1; k >= 0; k--) begin
            c = k;
            if (MODE == 1) begin
                c = int'(rr_ptr_q) + k;
                if (c >= CNT) c = c - CNT;
            end
            if (master_req_valid[IW'(c)]) sel = IW'(c);
        end
    end

    always_comb begin
        any_req          = |master_req_valid;
        full             = (occ_q == CW'(QUEUE_DEPTH));
        empty            = (occ_q == '0);
        slave_req_valid  = rst & any_req & ~full;
        slave_req_data   = master_req_data[sel];
        push             = slave_req_valid & slave_req_ready;
        master_req_ready = '0;
        if (push) master_req_ready[sel] = 1'b1;

        head_idx          = idx_q[rd_ptr_q];
        head_drop         = disc_q[rd_ptr_q] | flush[head_idx];
        master_resp_valid = '0;
        for (int i = 0; i < CNT; i++) master_resp_data[i] = slave_resp_data;
        if (slave_resp_valid & ~empty & ~head_drop)
            master_resp_valid[head_idx] = 1'b1;
        slave_resp_ready = ~empty & (head_drop | master_resp_ready[head_idx]);
        pop              = slave_resp_valid & slave_resp_ready;
    end

    // A flush marks matching entries, including one written in the same cycle.
    always_comb begin
        idx_d = idx_q;
        for (int j = 0; j < QUEUE_DEPTH; j++)
            disc_d[j] = disc_q[j] | flush[idx_q[j]];
        if (push) begin
            idx_d[wr_ptr_q]  = sel;
            disc_d[wr_ptr_q] = flush[sel];
        end
        wr_ptr_d = push ? nxt(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? nxt(rd_ptr_q) : rd_ptr_q;
        occ_d    = occ_q + CW'(push) - CW'(pop);
        rr_ptr_d = rr_ptr_q;
        if (MODE == 1 && push)
            rr_ptr_d = (sel == IW'(CNT - 1)) ? '0 : sel + IW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < QUEUE_DEPTH; j++) idx_q[j] <= '0;
            disc_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            idx_q    <= idx_d;
            disc_q   <= disc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [CNT-1:0][31:0] grant_cnt_q, grant_cnt_d;
    logic [31:0]          drop_cnt_q, drop_cnt_d;

    always_comb begin
        grant_cnt_d = grant_cnt_q;
        if (push) grant_cnt_d[sel] = grant_cnt_q[sel] + 32'd1;
        drop_cnt_d = drop_cnt_q + 32'(pop & head_drop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign grant_cnt = grant_cnt_q;
    assign drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_prio_mem_arbiter.sv
// Scoreboard bench for prio_mem_arbiter: fixed-priority (CNT 2) and round-robin (CNT 3)
// instances; counter checks run when MEM_ARB_STATS_EN is defined.
module tb_prio_mem_arbiter;

    typedef struct packed {
        logic [1:0]  ch;
        logic [31:0] d;
    } resp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [1:0]        m0_valid, m0_ready, m0_rvalid, m0_rready, flush0;
    logic [1:0][31:0]  m0_data, m0_rdata;
    logic              s0_valid, s0_ready, s0_rvalid, s0_rready;
    logic [31:0]       s0_data, s0_rdata;

    logic [2:0]        m1_valid, m1_ready, m1_rvalid, m1_rready, flush1;
    logic [2:0][31:0]  m1_data, m1_rdata;
    logic              s1_valid, s1_ready, s1_rvalid, s1_rready;
    logic [31:0]       s1_data, s1_rdata;

`ifdef MEM_ARB_STATS_EN
    logic [1:0][31:0]  gc0;
    logic [31:0]       dc0;
    logic [2:0][31:0]  gc1;
    logic [31:0]       dc1;
`endif

    prio_mem_arbiter #(.CNT(2), .QUEUE_DEPTH(2), .MODE(0), .REQ_W(32), .RESP_W(32)) u0 (
        .clk(clk), .rst(rst),
        .master_req_valid(m0_valid), .master_req_ready(m0_ready),
        .master_req_data(m0_data),
        .master_resp_valid(m0_rvalid), .master_resp_ready(m0_rready),
        .master_resp_data(m0_rdata),
        .slave_req_valid(s0_valid), .slave_req_ready(s0_ready),
        .slave_req_data(s0_data),
        .slave_resp_valid(s0_rvalid), .slave_resp_ready(s0_rready),
        .slave_resp_data(s0_rdata),
        .flush(flush0)
`ifdef MEM_ARB_STATS_EN
        , .grant_cnt(gc0), .drop_cnt(dc0)
`endif
    );

    prio_mem_arbiter #(.CNT(3), .QUEUE_DEPTH(2), .MODE(1), .REQ_W(32), .RESP_W(32)) u1 (
        .clk(clk), .rst(rst),
        .master_req_valid(m1_valid), .master_req_ready(m1_ready),
        .master_req_data(m1_data),
        .master_resp_valid(m1_rvalid), .master_resp_ready(m1_rready),
        .master_resp_data(m1_rdata),
        .slave_req_valid(s1_valid), .slave_req_ready(s1_ready),
        .slave_req_data(s1_data),
        .slave_resp_valid(s1_rvalid), .slave_resp_ready(s1_rready),
        .slave_resp_data(s1_rdata),
        .flush(flush1)
`ifdef MEM_ARB_STATS_EN
        , .grant_cnt(gc1), .drop_cnt(dc1)
`endif
    );

    int    errors = 0;
    int    checks = 0;
    int    exp_g0[$];
    int    exp_g1[$];
    resp_t exp_r0[$];
    resp_t exp_r1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic int idx_of(input logic [2:0] v);
        int r;
        r = -1;
        for (int i = 0; i < 3; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor for the fixed-priority instance.
    always @(negedge clk) begin : mon0
        int    g;
        int    e;
        resp_t r;
        if (rst) begin
            if (s0_valid && s0_ready) begin
                g = idx_of({1'b0, m0_ready});
                if (exp_g0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL g0_unexpected: got ch %0d want none", g);
                end else begin
                    e = exp_g0.pop_front();
                    check("g0_chan", g, e);
                    check("g0_data", s0_data, m0_data[e]);
                end
            end
            if (|m0_rvalid) begin
                g = idx_of({1'b0, m0_rvalid});
                if (exp_r0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL r0_unexpected: got ch %0d want none", g);
                end else if (|(m0_rvalid & m0_rready)) begin
                    r = exp_r0.pop_front();
                    check("r0_chan", g, 32'(r.ch));
                    check("r0_data", m0_rdata[g], r.d);
                end
            end
        end
    end

    // Monitor for the round-robin instance.
    always @(negedge clk) begin : mon1
        int    g;
        int    e;
        resp_t r;
        if (rst) begin
            if (s1_valid && s1_ready) begin
                g = idx_of(m1_ready);
                if (exp_g1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL g1_unexpected: got ch %0d want none", g);
                end else begin
                    e = exp_g1.pop_front();
                    check("g1_chan", g, e);
                    check("g1_data", s1_data, m1_data[e]);
                end
            end
            if (|m1_rvalid) begin
                g = idx_of(m1_rvalid);
                if (exp_r1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL r1_unexpected: got ch %0d want none", g);
                end else if (|(m1_rvalid & m1_rready)) begin
                    r = exp_r1.pop_front();
                    check("r1_chan", g, 32'(r.ch));
                    check("r1_data", m1_rdata[g], r.d);
                end
            end
        end
    end

    task automatic check_empty0(input string name);
        s0_rvalid = 1'b1;
        @(negedge clk);
        check(name, s0_rready, 0);
        cyc();
        s0_rvalid = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        m0_valid = '0; m0_rready = 2'b11; flush0 = '0;
        m0_data[0] = 32'h100; m0_data[1] = 32'h200;
        s0_ready = 1'b1; s0_rvalid = 1'b0; s0_rdata = '0;
        m1_valid = '0; m1_rready = 3'b111; flush1 = '0;
        m1_data[0] = 32'h10; m1_data[1] = 32'h11; m1_data[2] = 32'h12;
        s1_ready = 1'b1; s1_rvalid = 1'b0; s1_rdata = 32'hCAFE0000;

        // Outputs quiet while held in reset, even with requests present
        m0_valid = 2'b11; s0_rvalid = 1'b1; m1_valid = 3'b111; s1_rvalid = 1'b1;
        @(negedge clk);
        check("rst_sreq_valid0", s0_valid, 0);
        check("rst_mreq_ready0", m0_ready, 0);
        check("rst_sresp_ready0", s0_rready, 0);
        check("rst_mresp_valid0", m0_rvalid, 0);
        check("rst_sreq_valid1", s1_valid, 0);
        check("rst_mreq_ready1", m1_ready, 0);
        m0_valid = '0; s0_rvalid = 1'b0; m1_valid = '0; s1_rvalid = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();

        // Fixed priority: channel 0 wins twice, then the FIFO is full
        exp_g0.push_back(0);
        exp_g0.push_back(0);
        m0_valid = 2'b11;
        cyc();
        cyc();
        @(negedge clk);
        check("full_sreq_valid", s0_valid, 0);
        check("full_mreq_ready", m0_ready, 0);
        cyc();
        m0_valid = '0;
        exp_r0.push_back('{ch: 2'd0, d: 32'hA1});
        s0_rvalid = 1'b1; s0_rdata = 32'hA1;
        cyc();
        exp_r0.push_back('{ch: 2'd0, d: 32'hA2});
        s0_rdata = 32'hA2;
        cyc();
        s0_rvalid = 1'b0;
        check_empty0("drain_empty");

        // Flush of an accepted channel-1 request drops its response
        exp_g0.push_back(1);
        m0_data[1] = 32'h300;
        m0_valid = 2'b10;
        cyc();
        m0_valid = '0;
        flush0 = 2'b10;
        cyc();
        flush0 = '0;
        s0_rvalid = 1'b1; s0_rdata = 32'hDEADBEEF;
        @(negedge clk);
        check("flush_sresp_ready", s0_rready, 1);
        check("flush_mresp_valid", m0_rvalid, 0);
        cyc();
        s0_rvalid = 1'b0;
        check_empty0("flush_empty");

        // Flush in the same cycle as the push still marks the entry
        exp_g0.push_back(0);
        m0_data[0] = 32'h350;
        m0_valid = 2'b01; flush0 = 2'b01;
        cyc();
        m0_valid = '0; flush0 = '0;
        s0_rvalid = 1'b1; s0_rdata = 32'h55;
        @(negedge clk);
        check("samecyc_sresp_ready", s0_rready, 1);
        check("samecyc_mresp_valid", m0_rvalid, 0);
        cyc();
        s0_rvalid = 1'b0;
        check_empty0("samecyc_empty");

        // Responses routed in request order; channel-1 backpressure stalls slave
        exp_g0.push_back(0);
        m0_data[0] = 32'h400;
        m0_valid = 2'b01;
        cyc();
        exp_g0.push_back(1);
        m0_data[1] = 32'h500;
        m0_valid = 2'b10;
        cyc();
        m0_valid = '0;
        exp_r0.push_back('{ch: 2'd0, d: 32'hAAAA});
        s0_rvalid = 1'b1; s0_rdata = 32'hAAAA;
        cyc();
        exp_r0.push_back('{ch: 2'd1, d: 32'hBBBB});
        s0_rdata = 32'hBBBB;
        m0_rready = 2'b01;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_sresp_ready", s0_rready, 0);
            check("stall_mresp_valid", m0_rvalid, 2'b10);
            cyc();
        end
        m0_rready = 2'b11;
        cyc();
        s0_rvalid = 1'b0;
        check_empty0("order_empty");

        // Round robin with immediate responses
        s1_rvalid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_g1.push_back(i % 3);
            exp_r1.push_back('{ch: 2'(i % 3), d: 32'hCAFE0000});
        end
        m1_valid = 3'b111;
        repeat (6) cyc();
        m1_valid = '0;
        cyc();
        exp_g1.push_back(0);
        exp_r1.push_back('{ch: 2'd0, d: 32'hCAFE0000});
        m1_valid = 3'b001;
        cyc();
        m1_valid = '0;
        cyc();

        // Reset with two entries outstanding on the fixed-priority instance
        exp_g0.push_back(0);
        exp_g0.push_back(0);
        m0_valid = 2'b11;
        cyc();
        cyc();
        m0_valid = '0;
        rst = 1'b0;
        s0_rvalid = 1'b1; s0_rdata = 32'h77;
        #1;
        check("midrst_sresp_ready", s0_rready, 0);
        cyc();
        rst = 1'b1;
        @(negedge clk);
        check("postrst_sresp_ready0", s0_rready, 0);
        check("postrst_sresp_ready1", s1_rready, 0);
        cyc();
        s0_rvalid = 1'b0;
        // rr pointer back at 0 picks channel 0 over 2
        exp_g1.push_back(0);
        exp_r1.push_back('{ch: 2'd0, d: 32'hCAFE0000});
        m1_valid = 3'b101;
        cyc();
        m1_valid = '0;
        cyc();
        s1_rvalid = 1'b0;

`ifdef MEM_ARB_STATS_EN
        for (int i = 0; i < 5; i++) begin
            exp_g0.push_back(0);
            m0_data[0] = 32'h700 + 32'(i);
            m0_valid = 2'b01;
            cyc();
            m0_valid = '0;
            if (i < 4) begin
                exp_r0.push_back('{ch: 2'd0, d: 32'h800 + 32'(i)});
                s0_rvalid = 1'b1; s0_rdata = 32'h800 + 32'(i);
                cyc();
                s0_rvalid = 1'b0;
            end else begin
                flush0 = 2'b01;
                cyc();
                flush0 = '0;
                s0_rvalid = 1'b1;
                cyc();
                s0_rvalid = 1'b0;
            end
        end
        @(negedge clk);
        check("stats_grant0", gc0[0], 5);
        check("stats_grant1", gc0[1], 0);
        check("stats_drop", dc0, 1);
        check("stats_rr_grant0", gc1[0], 1);
        cyc();
`endif

        repeat (2) cyc();
        check("g0_left", exp_g0.size(), 0);
        check("r0_left", exp_r0.size(), 0);
        check("g1_left", exp_g1.size(), 0);
        check("r1_left", exp_r1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
